// File: rtl/sqrt_share_ctrl_pkg.sv
// rtl/sqrt_share_ctrl_pkg.sv - shared widths, latency default and FSM encodings for the sqrt sharer
package sqrt_share_ctrl_pkg;

  localparam int SQRT_IN_W        = 31;
  localparam int SQRT_OUT_W       = 17;
  localparam int SQRT_LAT_DEFAULT = 2;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/sqrt_share_ctrl_rr_arbiter.sv
// rtl/sqrt_share_ctrl_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  next_ptr
);

  logic [2*NREQ-1:0] req2;
  logic [2*NREQ-1:0] gnt2;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   gnt_rot;
  logic              found;

  // Rotate so ptr sits at bit 0, pick the lowest set bit, then rotate back.
  always_comb begin
    req2    = {req, req};
    rot     = NREQ'(req2 >> ptr);
    gnt_rot = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        gnt_rot[k] = 1'b1;
        found      = 1'b1;
      end
    end
    gnt2  = {{NREQ{1'b0}}, gnt_rot} << ptr;
    grant = gnt2[NREQ-1:0] | gnt2[2*NREQ-1:NREQ];
  end

  always_comb begin
    next_ptr = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        next_ptr = (i == NREQ - 1) ? '0 : IDW'(i + 1);
      end
    end
  end

endmodule

// File: rtl/sqrt_share_ctrl.sv
// rtl/sqrt_share_ctrl.sv - time-shares one fixed-latency sqrt among NREQ requesters with tagged returns
module sqrt_share_ctrl
  import sqrt_share_ctrl_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int SQRT_LAT = SQRT_LAT_DEFAULT,
  parameter int CNTW     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*SQRT_IN_W-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      flush,
  output logic [SQRT_IN_W-1:0]      sqrt_in,
  input  logic [SQRT_OUT_W-1:0]     sqrt_out,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [SQRT_OUT_W-1:0]     rsp_data,
  output logic                      busy,
  output logic                      flush_done,
  output logic [CNTW-1:0]           issue_cnt
);

  logic [1:0]                  state_q, state_d;
  logic [IDW-1:0]              ptr_q, ptr_d;
  logic [IDW-1:0]              next_ptr;
  logic [IDW-1:0]              grant_id;
  logic [NREQ-1:0]             req_gated;
  logic [NREQ-1:0]             grant;
  logic                        arb_en;
  logic                        issue;
  logic [SQRT_LAT:0]           tag_v_q, tag_v_d;
  logic [SQRT_LAT:0][IDW-1:0]  tag_id_q, tag_id_d;
  logic [SQRT_IN_W-1:0]        sqrt_in_q, sqrt_in_d;
  logic [NREQ-1:0]             rsp_valid_q, rsp_valid_d;
  logic [SQRT_OUT_W-1:0]       rsp_data_q, rsp_data_d;
  logic                        flush_done_q, flush_done_d;
  logic [CNTW-1:0]             issue_cnt_q, issue_cnt_d;

  // flush gates the grant in the same cycle it rises, before the FSM leaves RUN.
  assign arb_en    = (state_q == ST_RUN) && !flush && !rst;
  assign req_gated = arb_en ? req_valid : '0;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req      (req_gated),
    .ptr      (ptr_q),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  assign issue      = |grant;
  assign req_ready  = grant;
  assign busy       = |tag_v_q;
  assign sqrt_in    = sqrt_in_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign flush_done = flush_done_q;
  assign issue_cnt  = issue_cnt_q;

  always_comb begin
    grant_id  = '0;
    sqrt_in_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_id  = IDW'(i);
        sqrt_in_d = req_data[SQRT_IN_W*i +: SQRT_IN_W];
      end
    end
  end

  always_comb begin
    ptr_d       = issue ? next_ptr : ptr_q;
    issue_cnt_d = issue_cnt_q + CNTW'(issue);
    tag_v_d     = {tag_v_q[SQRT_LAT-1:0], issue};
    tag_id_d    = {tag_id_q[SQRT_LAT-1:0], grant_id};
  end

  // The last tag stage lines up with the sqrt result for that operand.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_v_q[SQRT_LAT]) begin
      rsp_valid_d = NREQ'(1) << tag_id_q[SQRT_LAT];
      rsp_data_d  = sqrt_out;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!flush)     state_d = ST_RUN;
        else if (!busy) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!flush) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    flush_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      ptr_q        <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      sqrt_in_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      flush_done_q <= 1'b0;
      issue_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      sqrt_in_q    <= sqrt_in_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      flush_done_q <= flush_done_d;
      issue_cnt_q  <= issue_cnt_d;
    end
  end

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// tb/tb_sqrt_share_ctrl.sv - scoreboard bench for sqrt_share_ctrl with a 2-stage integer sqrt stand-in
module tb_sqrt_share_ctrl;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 2;
  localparam int CNTW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic [NREQ-1:0]      req_valid = 4'hF;
  logic [NREQ*31-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [30:0]          sqrt_in;
  logic [16:0]          sqrt_out;
  logic [NREQ-1:0]      rsp_valid;
  logic [16:0]          rsp_data;
  logic                 busy;
  logic                 flush_done;
  logic [CNTW-1:0]      issue_cnt;

  sqrt_share_ctrl #(
    .NREQ     (NREQ),
    .IDW      (IDW),
    .SQRT_LAT (LAT),
    .CNTW     (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .flush      (flush),
    .sqrt_in    (sqrt_in),
    .sqrt_out   (sqrt_out),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .flush_done (flush_done),
    .issue_cnt  (issue_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] isqrt(input logic [30:0] x);
    longint r;
    longint t;
    r = 0;
    for (int b = 16; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= longint'(x)) r = t;
    end
    return 17'(r);
  endfunction

  // Stand-in sqrt datapath: two unreset stages, SQRT_LAT=2.
  logic [16:0] s1_q, s2_q;
  always @(posedge clk) begin
    s1_q <= isqrt(sqrt_in);
    s2_q <= s1_q;
  end
  assign sqrt_out = s2_q;

  typedef struct {
    int          id;
    logic [16:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          exp_cnt = 0;
  logic        busy_s;
  logic        fd_s;
  logic [30:0] operand [NREQ] = '{31'd100, 31'd400, 31'd1024, 31'd2025};
  logic [16:0] exp_root [NREQ] = '{17'd10, 17'd20, 17'd32, 17'd45};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: drive req_valid, check the grant, queue the expected response.
  task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] exp_g);
    exp_t e;
    req_valid = v;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_g));
    busy_s = busy;
    fd_s   = flush_done;
    if (exp_g != '0) begin
      for (int i = 0; i < NREQ; i++) if (exp_g[i]) e.id = i;
      e.data = exp_root[e.id];
      e.cyc  = cyc + 4;
      sb.push_back(e);
      exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b expected none (cycle %0d)", rsp_valid, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(4'b1 << mon_e.id));
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        chk("rsp_latency", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cb;
    int cf;
    for (int i = 0; i < NREQ; i++) req_data[31*i +: 31] = operand[i];

    // Reset held with all requesters valid
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_issue_cnt", 32'(issue_cnt), 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    req_valid = '0;

    // Single requester 2, operand 1024
    drive(4'b0100, 4'b0100);
    for (int k = 0; k < 5; k++) drive(4'b0000, 4'b0000);
    chk("single_issue_cnt", 32'(issue_cnt), 1);

    // Move ptr to 0, then full round-robin
    drive(4'b1000, 4'b1000);
    drive(4'hF, 4'b0001);
    drive(4'hF, 4'b0010);
    drive(4'hF, 4'b0100);
    drive(4'hF, 4'b1000);
    drive(4'hF, 4'b0001);
    drive(4'hF, 4'b0010);
    drive(4'hF, 4'b0100);
    drive(4'hF, 4'b1000);
    for (int k = 0; k < 5; k++) drive(4'b0000, 4'b0000);
    chk("rr_issue_cnt", 32'(issue_cnt), 32'(exp_cnt));

    // Sparse requesters 0 and 3
    drive(4'b1001, 4'b0001);
    drive(4'b1001, 4'b1000);
    drive(4'b1001, 4'b0001);
    drive(4'b1001, 4'b1000);
    for (int k = 0; k < 5; k++) drive(4'b0000, 4'b0000);

    // Flush after three back-to-back issues
    drive(4'hF, 4'b0001);
    drive(4'hF, 4'b0010);
    drive(4'hF, 4'b0100);
    flush = 1'b1;
    cb = -1;
    cf = -1;
    for (int k = 0; k < 10; k++) begin
      drive(4'hF, 4'b0000);
      if (cb < 0 && !busy_s) cb = k;
      if (cf < 0 && fd_s) cf = k;
    end
    chk("flush_busy_fell", 32'(cb >= 0), 1);
    chk("flush_done_delay", cf, cb + 1);
    flush = 1'b0;
    drive(4'hF, 4'b0000);
    chk("flush_done_hold", 32'(fd_s), 1);
    drive(4'hF, 4'b1000);
    chk("flush_done_clear", 32'(fd_s), 0);
    for (int k = 0; k < 6; k++) drive(4'b0000, 4'b0000);
    chk("flush_issue_cnt", 32'(issue_cnt), 32'(exp_cnt));

    // Reset with two operations in flight
    drive(4'hF, 4'b0001);
    drive(4'hF, 4'b0010);
    rst = 1'b1;
    req_valid = '0;
    sb.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) drive(4'b0000, 4'b0000);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_issue_cnt", 32'(issue_cnt), 0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
